// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code engine.
// Contents:
//   gray_mode_t      2-bit beat mode
//   GRAY_MODE_*      mode encodings (2'b11 is reserved and behaves as ENC)
//   bin2gray/gray2bin  conversions on up to 32 bits; narrower callers zero-extend
//                      the argument and truncate the result, which is exact
//                      because zero upper bits contribute nothing to either
//                      transform.
package gray_pkg;

    typedef logic [1:0] gray_mode_t;

    localparam gray_mode_t GRAY_MODE_ENC = 2'b00;
    localparam gray_mode_t GRAY_MODE_DEC = 2'b01;
    localparam gray_mode_t GRAY_MODE_CNT = 2'b10;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        // Prefix XOR from the MSB down.
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i + 1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_codec_if.sv
// Handshake bus for gray_codec.
//   i_en/o_ready     input beat handshake, with i_mode and i_data
//   o_valid/i_ready  output beat handshake, with o_data, o_alt, o_err
// Modports: master = producer/consumer side, slave = gray_codec side.
interface gray_codec_if
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) ();

    logic             i_en;
    logic             o_ready;
    gray_mode_t       i_mode;
    logic [WIDTH-1:0] i_data;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic [WIDTH-1:0] o_alt;
    logic             o_err;

    modport master (
        output i_en, i_mode, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_alt, o_err
    );

    modport slave (
        input  i_en, i_mode, i_data, i_ready,
        output o_ready, o_valid, o_data, o_alt, o_err
    );

endinterface

// File: rtl/gray_conv.sv
// Combinational Gray converter.
//   din   operand (binary for ENC/CNT, gray for DEC)
//   mode  beat mode; anything other than DEC encodes
//   dout  primary result (gray for ENC/CNT, binary for DEC)
//   alt   other representation of the same value, which is always din
module gray_conv
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] din,
    input  gray_mode_t       mode,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] alt
);

    logic [31:0] din_ext;

    always_comb begin
        din_ext = 32'(din);
        if (mode == GRAY_MODE_DEC) begin
            dout = WIDTH'(gray2bin(din_ext));
        end else begin
            dout = WIDTH'(bin2gray(din_ext));
        end
        alt = din;
    end

endmodule

// File: rtl/gray_codec.sv
// Handshaked Gray-code engine: per-beat ENC / DEC / CNT with one registered
// output stage and downstream backpressure.
// Ports:
//   clk  clock
//   rst  asynchronous active-low reset
//   bus  gray_codec_if.slave (input beat, output beat, o_err)
// Parameters: WIDTH (2..32), CNT_INIT (counter reset value).
// Build option: define GRAY_CODEC_ERR_EN to enable the DEC adjacency checker;
// without it o_err is tied 0 and no checker storage exists.
module gray_codec
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CNT_INIT = 0
) (
    input logic         clk,
    input logic         rst,
    gray_codec_if.slave bus
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] alt_q;
    logic             err_q;
    logic [WIDTH-1:0] cnt_q;

    logic             accept;
    logic             is_cnt;
    logic             is_dec;
    logic             err_d;
    logic [WIDTH-1:0] conv_din;
    logic [WIDTH-1:0] conv_dout;
    logic [WIDTH-1:0] conv_alt;

    // A held beat blocks intake; a draining beat frees the slot the same cycle.
    assign bus.o_ready = ~valid_q | bus.i_ready;
    assign accept      = bus.i_en & bus.o_ready;
    assign is_cnt      = (bus.i_mode == GRAY_MODE_CNT);
    assign is_dec      = (bus.i_mode == GRAY_MODE_DEC);
    assign conv_din    = is_cnt ? cnt_q : bus.i_data;

    gray_conv #(
        .WIDTH(WIDTH)
    ) u_conv (
        .din (conv_din),
        .mode(bus.i_mode),
        .dout(conv_dout),
        .alt (conv_alt)
    );

`ifdef GRAY_CODEC_ERR_EN
    logic [WIDTH-1:0] last_q;
    logic             seen_q;
    logic [WIDTH-1:0] diff;

    // More than one bit set iff clearing the lowest set bit leaves something.
    always_comb begin
        diff  = bus.i_data ^ last_q;
        err_d = is_dec & seen_q & (|(diff & (diff - WIDTH'(1))));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= '0;
            seen_q <= 1'b0;
        end else if (accept && is_dec) begin
            last_q <= bus.i_data;
            seen_q <= 1'b1;
        end
    end
`else
    assign err_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            alt_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= WIDTH'(CNT_INIT);
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= conv_dout;
            alt_q   <= conv_alt;
            err_q   <= err_d;
            if (is_cnt) begin
                cnt_q <= cnt_q + WIDTH'(1);
            end
        end else if (bus.i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_data  = data_q;
    assign bus.o_alt   = alt_q;
    assign bus.o_err   = err_q;

endmodule

// File: tb/tb_gray_codec.sv
// Self-checking bench for gray_codec (WIDTH=4, CNT_INIT=0).
// The reference uses a reflected Gray list built by mirroring, decodes by
// table search and counts with plain modulo arithmetic.
module tb_gray_codec;
    import gray_pkg::*;

    localparam int W = 4;
    localparam int N = 16;
`ifdef GRAY_CODEC_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gray_codec_if #(.WIDTH(W)) bus ();

    gray_codec #(
        .WIDTH   (W),
        .CNT_INIT(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int glist[N];
    int cnt_seq[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

    // Reference state
    bit m_valid;
    int m_data, m_alt, m_cnt, m_last;
    bit m_err, m_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int enc(input int b);
        return glist[b];
    endfunction

    function automatic int dec(input int g);
        for (int i = 0; i < N; i++) begin
            if (glist[i] == g) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 0;
        m_alt   = 0;
        m_err   = 1'b0;
        m_cnt   = 0;
        m_last  = 0;
        m_seen  = 1'b0;
    endtask

    // One clock: drive, check current outputs, advance the model, step past the edge.
    task automatic cycle(input bit en, input int mode, input int data, input bit rdy);
        bit acc;
        bus.i_en    = en;
        bus.i_mode  = gray_mode_t'(mode);
        bus.i_data  = 4'(data);
        bus.i_ready = rdy;
        #1;
        chk("o_ready", {31'd0, bus.o_ready}, {31'd0, (!m_valid || rdy)});
        chk("o_valid", {31'd0, bus.o_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("o_data", 32'(bus.o_data), m_data);
            chk("o_alt", 32'(bus.o_alt), m_alt);
            chk("o_err", {31'd0, bus.o_err}, {31'd0, m_err});
        end
        acc = en && (!m_valid || rdy);
        if (acc) begin
            m_err = 1'b0;
            if (mode == 1) begin
                m_data = dec(data);
                m_alt  = data;
                if (ERR_ON) begin
                    m_err  = m_seen && ($countones(data ^ m_last) > 1);
                    m_last = data;
                    m_seen = 1'b1;
                end
            end else if (mode == 2) begin
                m_data = enc(m_cnt);
                m_alt  = m_cnt;
                m_cnt  = (m_cnt + 1) % N;
            end else begin
                m_data = enc(data);
                m_alt  = data;
            end
            m_valid = 1'b1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int len;
        logic [W-1:0] prev;
        logic [W-1:0] hold;

        // Reflected Gray list: mirror the list so far and set the next bit.
        glist[0] = 0;
        len = 1;
        for (int k = 0; k < W; k++) begin
            for (int i = 0; i < len; i++) begin
                glist[len + i] = glist[len - 1 - i] | (1 << k);
            end
            len = len * 2;
        end

        model_reset();
        bus.i_en    = 1'b0;
        bus.i_mode  = GRAY_MODE_ENC;
        bus.i_data  = '0;
        bus.i_ready = 1'b0;

        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, bus.o_valid}, 0);
        chk("rst_data", 32'(bus.o_data), 0);
        chk("rst_alt", 32'(bus.o_alt), 0);
        chk("rst_err", {31'd0, bus.o_err}, 0);
        rst = 1'b1;

        // ENC 0101 -> 0111
        cycle(1'b1, 0, 5, 1'b1);
        chk("enc_5", 32'(bus.o_data), 32'h7);
        chk("enc_5_alt", 32'(bus.o_alt), 32'h5);
        for (int b = 0; b < N; b++) cycle(1'b1, 0, b, 1'b1);
        cycle(1'b1, 3, 9, 1'b1);  // reserved mode behaves as ENC

        // DEC 0111 -> 0101, then round-trip every Gray code
        cycle(1'b1, 1, 7, 1'b1);
        chk("dec_7", 32'(bus.o_data), 32'h5);
        for (int b = 0; b < N; b++) begin
            cycle(1'b1, 1, enc(b), 1'b1);
            chk("dec_roundtrip", 32'(bus.o_data), b);
        end

        // CNT: 17 beats from reset value, wrapping once
        prev = '0;
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 2, int'($urandom_range(0, 15)), 1'b1);
            chk("cnt_seq", 32'(bus.o_data), cnt_seq[i]);
            if (i > 0) chk("cnt_1bit", $countones(bus.o_data ^ prev), 1);
            prev = bus.o_data;
        end

        // Backpressure: five stalled cycles, then resume
        hold = bus.o_data;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 2, 0, 1'b0);
            chk("bp_hold", 32'(bus.o_data), 32'(hold));
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 2, 0, 1'b1);
        cycle(1'b0, 0, 0, 1'b1);

        // Random mixed traffic
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end

        // Reset mid-stream during a CNT run
        for (int i = 0; i < 3; i++) cycle(1'b1, 2, 0, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, bus.o_valid}, 0);
        chk("midrst_data", 32'(bus.o_data), 0);
        model_reset();
        bus.i_en   = 1'b1;
        bus.i_mode = GRAY_MODE_CNT;
        @(posedge clk);
        #1;
        chk("inrst_valid", {31'd0, bus.o_valid}, 0);
        rst = 1'b1;
        cycle(1'b1, 2, 0, 1'b1);
        chk("post_rst_cnt", 32'(bus.o_data), 0);
        chk("post_rst_alt", 32'(bus.o_alt), 0);

        // Adjacency checker
        cycle(1'b1, 1, 0, 1'b1);
        cycle(1'b1, 1, 3, 1'b1);
        chk("err_adj", {31'd0, bus.o_err}, {31'd0, ERR_ON});
        cycle(1'b1, 1, 1, 1'b1);
        chk("err_ok", {31'd0, bus.o_err}, 0);
        cycle(1'b1, 1, 1, 1'b1);
        chk("err_repeat", {31'd0, bus.o_err}, 0);
        cycle(1'b1, 0, 15, 1'b1);
        chk("err_enc", {31'd0, bus.o_err}, 0);
        cycle(1'b0, 0, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
